// File: rtl/seven_seg_if.sv
// Segment-frame and display-drive bundle between the score path and the scanner.
interface seven_seg_if;
    logic [27:0] frame_in;
    logic        frame_load;
    logic        blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    modport master (
        output frame_in, frame_load, blank,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  frame_in, frame_load, blank,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode driver with double-buffered, tear-free frame commit.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    seven_seg_if.slave  bus
);

    localparam int unsigned PCNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIG_N   = 4;
    localparam int unsigned FRAME_W = SEG_W * DIG_N;

    localparam logic [FRAME_W-1:0] FRAME_OFF = {FRAME_W{1'b1}};
    localparam logic [SEG_W-1:0]   SEG_OFF   = {SEG_W{1'b1}};
    localparam logic [DIG_N-1:0]   AN_OFF    = {DIG_N{1'b1}};

    // Encoding equals the digit number, so it doubles as the anode bit position.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_e;

    dig_e               idx, idx_nxt;
    logic [PCNT_W-1:0]  pcnt;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] active;
    logic               pending;
    logic               live;
    logic [DIG_N-1:0]   lzb_mask;

    logic               slot_tick_c;
    logic               boundary_c;
    logic               commit_c;
    logic [FRAME_W-1:0] commit_frame_c;
    logic [SEG_W-1:0]   slice_c;
    logic [SEG_W-1:0]   seg_c;
    logic [DIG_N-1:0]   an_c;
    logic               frame_start_c;

    assign slot_tick_c    = (pcnt == PCNT_W'(REFRESH_DIV - 1));
    assign boundary_c     = slot_tick_c && (idx == DIG0);
    assign commit_c       = boundary_c && (bus.frame_load || pending);
    assign commit_frame_c = bus.frame_load ? bus.frame_in : shadow;

    // Slot prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (slot_tick_c) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    // Digit FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= DIG3;
        end else begin
            idx <= idx_nxt;
        end
    end

    // Digit FSM: next state, scanning leftmost to rightmost
    always_comb begin
        idx_nxt = idx;
        if (slot_tick_c) begin
            case (idx)
                DIG3:    idx_nxt = DIG2;
                DIG2:    idx_nxt = DIG1;
                DIG1:    idx_nxt = DIG0;
                DIG0:    idx_nxt = DIG3;
                default: idx_nxt = DIG3;
            endcase
        end
    end

    // Double buffer; a load on the boundary itself bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= FRAME_OFF;
            active  <= FRAME_OFF;
            pending <= 1'b0;
            live    <= 1'b0;
        end else if (boundary_c) begin
            if (commit_c) begin
                active  <= commit_frame_c;
                pending <= 1'b0;
                live    <= 1'b1;
            end
        end else if (bus.frame_load) begin
            shadow  <= bus.frame_in;
            pending <= 1'b1;
        end
    end

`ifdef SEVEN_SEG_LZB_EN
    // Mask of leading digits showing '0'; digit 0 is never blanked.
    function automatic logic [DIG_N-1:0] lzb_f(input logic [FRAME_W-SEG_W-1:0] f);
        logic [DIG_N-1:0] m;
        m[3] = (f[20:14] == 7'b1000000);
        m[2] = m[3] && (f[13:7] == 7'b1000000);
        m[1] = m[2] && (f[6:0] == 7'b1000000);
        m[0] = 1'b0;
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lzb_mask <= '0;
        end else if (commit_c) begin
            lzb_mask <= lzb_f(commit_frame_c[FRAME_W-1:SEG_W]);
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Digit FSM: output decode
    always_comb begin
        slice_c       = SEG_OFF;
        an_c          = AN_OFF;
        seg_c         = SEG_OFF;
        frame_start_c = (idx == DIG3) && (pcnt == '0);
        case (idx)
            DIG3:    slice_c = active[27:21];
            DIG2:    slice_c = active[20:14];
            DIG1:    slice_c = active[13:7];
            DIG0:    slice_c = active[6:0];
            default: slice_c = SEG_OFF;
        endcase
        // Display stays dark until the first commit after reset.
        if (live && !bus.blank && (pcnt >= PCNT_W'(DEAD_CYCLES)) && !lzb_mask[idx]) begin
            an_c  = ~(DIG_N'(1) << idx);
            seg_c = slice_c;
        end
    end

    // Registered display drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.seg         <= SEG_OFF;
            bus.dp          <= 1'b1;
            bus.an          <= AN_OFF;
            bus.frame_start <= 1'b0;
        end else begin
            bus.seg         <= seg_c;
            bus.dp          <= 1'b1;
            bus.an          <= an_c;
            bus.frame_start <= frame_start_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: randomized loads/blanking against a cycle-count reference model.
module tb_seven_seg_scanner;

    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * DIV;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    seven_seg_if bus();

    seven_seg_scanner #(.REFRESH_DIV(DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position in the frame derives purely from cycles since reset.
    int unsigned  m_cyc;
    logic [27:0]  m_active;
    logic [27:0]  m_shadow;
    bit           m_pend;
    bit           m_live;
    logic [3:0]   e_an;
    logic [6:0]   e_seg;
    logic         e_dp;
    logic         e_fs;
    int           m_pos;
    int           m_dig;
    bit           m_lit;

    function automatic bit lz_dark(input logic [27:0] f, input int d);
        bit en;
        bit dark;
`ifdef SEVEN_SEG_LZB_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        dark = (d != 0);
        for (int k = 3; k >= d; k--)
            if (f[k*7 +: 7] != 7'h40) dark = 1'b0;
        return en && dark;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_active = '1; m_shadow = '1; m_pend = 0; m_live = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            m_pos = int'(m_cyc % DIV);
            m_dig = 3 - int'((m_cyc / DIV) % 4);
            m_lit = m_live && !bus.blank && (m_pos >= DEAD) && !lz_dark(m_active, m_dig);
            e_an  = m_lit ? ~(4'b0001 << m_dig) : 4'hF;
            e_seg = m_lit ? m_active[m_dig*7 +: 7] : 7'h7F;
            e_fs  = (m_cyc % FRAME) == 0;
            e_dp  = 1'b1;
            if (m_pos == DIV - 1 && m_dig == 0) begin
                if (bus.frame_load) begin
                    m_active = bus.frame_in; m_pend = 0; m_live = 1;
                end else if (m_pend) begin
                    m_active = m_shadow; m_pend = 0; m_live = 1;
                end
            end else if (bus.frame_load) begin
                m_shadow = bus.frame_in; m_pend = 1;
            end
            m_cyc++;
        end
    end

    // Advance to the negedge where the model's frame phase equals ph.
    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * FRAME && (m_cyc % FRAME) != ph; i++) @(negedge clk);
    endtask

    task automatic load(input logic [27:0] f);
        bus.frame_in = f; bus.frame_load = 1'b1;
        @(negedge clk);
        bus.frame_load = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values an=%b seg=%h dp=%b fs=%b want an=1111 seg=7f dp=1 fs=0",
                     bus.an, bus.seg, bus.dp, bus.frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_dark;
        int fs_n;
        int fs_at[2];
        fs_n = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.dp !== e_dp || bus.frame_start !== e_fs) begin
                n_err++;
                $display("FAIL idle_model i=%0d an=%b/%b seg=%h/%h fs=%b/%b", i, bus.an, e_an, bus.seg, e_seg, bus.frame_start, e_fs);
            end
            n_vec++;
            if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin
                n_err++;
                $display("FAIL idle_dark i=%0d an=%b seg=%h want 1111/7f", i, bus.an, bus.seg);
            end
            if (bus.frame_start === 1'b1) begin
                if (fs_n < 2) fs_at[fs_n] = i;
                fs_n++;
            end
        end
        n_vec++;
        if (fs_n != 2 || fs_at[0] != 0 || fs_at[1] != FRAME) begin
            n_err++;
            $display("FAIL idle_frame_start pulses=%0d first=%0d second=%0d want 2/0/%0d", fs_n, fs_at[0], fs_at[1], FRAME);
        end
    endtask

    task automatic test_load_mid_dig2;
        logic [6:0] pat [4];
        logic [3:0] ans [4];
        logic [3:0] xa;
        logic [6:0] xs;
        pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30;
        ans[0] = 4'b0111; ans[1] = 4'b1011; ans[2] = 4'b1101; ans[3] = 4'b1110;
        wait_phase(DIV + 4);
        load({pat[0], pat[1], pat[2], pat[3]});
        for (int i = 0; i < 2 * FRAME && (m_cyc % FRAME) != 1; i++) begin
            n_vec++;
            if (bus.an !== 4'hF || bus.an !== e_an) begin
                n_err++;
                $display("FAIL load_before_boundary an=%b want 1111", bus.an);
            end
            @(negedge clk);
        end
        for (int i = 0; i < FRAME; i++) begin
            xa = ((i % DIV) < DEAD) ? 4'hF : ans[i / DIV];
            xs = ((i % DIV) < DEAD) ? 7'h7F : pat[i / DIV];
            n_vec++;
            if (bus.an !== xa || bus.seg !== xs || bus.frame_start !== (i == 0)) begin
                n_err++;
                $display("FAIL load_frame i=%0d an=%b/%b seg=%h/%h fs=%b", i, bus.an, xa, bus.seg, xs, bus.frame_start);
            end
            n_vec++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs) begin
                n_err++;
                $display("FAIL load_model i=%0d an=%b/%b seg=%h/%h", i, bus.an, e_an, bus.seg, e_seg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [27:0] fa;
        logic [27:0] fb;
        int lit;
        int d;
        fa = 28'($urandom);
        fb = ~fa;
        lit = 0;
        wait_phase(2);
        load(fa);
        wait_phase(20);
        load(fb);
        wait_phase(1);
        for (int i = 0; i < FRAME; i++) begin
            n_vec++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs) begin
                n_err++;
                $display("FAIL b2b_model i=%0d an=%b/%b seg=%h/%h", i, bus.an, e_an, bus.seg, e_seg);
            end
            if (bus.an !== 4'hF) begin
                lit++;
                d = 3 - i / DIV;
                n_vec++;
                if (bus.seg !== fb[d*7 +: 7]) begin
                    n_err++;
                    $display("FAIL b2b_last_wins i=%0d seg=%h want %h (first load %h)", i, bus.seg, fb[d*7 +: 7], fa[d*7 +: 7]);
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (lit != 4 * (DIV - DEAD)) begin
            n_err++;
            $display("FAIL b2b_lit_cycles got %0d want %0d", lit, 4 * (DIV - DEAD));
        end
    endtask

    task automatic test_boundary_load;
        logic [27:0] fc;
        logic [27:0] fd;
        int lit;
        int d;
        fd = 28'($urandom);
        fc = ~fd;
        lit = 0;
        wait_phase(5);
        load(fd);
        wait_phase(FRAME - 1);
        load(fc);
        @(negedge clk);
        for (int i = 0; i < 2 * FRAME; i++) begin
            n_vec++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs) begin
                n_err++;
                $display("FAIL bnd_model i=%0d an=%b/%b seg=%h/%h", i, bus.an, e_an, bus.seg, e_seg);
            end
            if (bus.an !== 4'hF) begin
                lit++;
                d = 3 - (i % FRAME) / DIV;
                n_vec++;
                if (bus.seg !== fc[d*7 +: 7]) begin
                    n_err++;
                    $display("FAIL bnd_load i=%0d seg=%h want %h", i, bus.seg, fc[d*7 +: 7]);
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (lit != 8 * (DIV - DEAD)) begin
            n_err++;
            $display("FAIL bnd_lit_cycles got %0d want %0d", lit, 8 * (DIV - DEAD));
        end
    endtask

    task automatic test_blank;
        wait_phase(2 * DIV + 1);
        bus.blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.an !== 4'hF || bus.an !== e_an) begin
                n_err++;
                $display("FAIL blank_dark i=%0d an=%b want 1111", i, bus.an);
            end
        end
        bus.blank = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.frame_start !== e_fs) begin
                n_err++;
                $display("FAIL blank_resume i=%0d an=%b/%b seg=%h/%h", i, bus.an, e_an, bus.seg, e_seg);
            end
            n_vec++;
            if (bus.frame_start !== ((m_cyc % FRAME) == 1)) begin
                n_err++;
                $display("FAIL blank_cadence i=%0d fs=%b want %b", i, bus.frame_start, (m_cyc % FRAME) == 1);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.an !== e_an || bus.seg !== e_seg || bus.dp !== e_dp || bus.frame_start !== e_fs) begin
                n_err++;
                $display("FAIL random i=%0d an=%b/%b seg=%h/%h dp=%b fs=%b/%b", i, bus.an, e_an, bus.seg, e_seg, bus.dp, bus.frame_start, e_fs);
            end
            bus.frame_in   = 28'($urandom);
            bus.frame_load = ($urandom % 6) == 0;
            bus.blank      = ($urandom % 10) == 0;
        end
        @(negedge clk);
        bus.frame_load = 1'b0;
        bus.blank      = 1'b0;
    endtask

`ifdef SEVEN_SEG_LZB_EN
    task automatic test_lzb;
        int lit0;
        wait_phase(3);
        load({7'h40, 7'h40, 7'h19, 7'h40});
        wait_phase(1);
        for (int i = 0; i < FRAME; i++) begin
            n_vec++;
            if (bus.an[3] !== 1'b1 || bus.an[2] !== 1'b1 || bus.an !== e_an ||
                (bus.an === 4'b1101 && bus.seg !== 7'h19) || (bus.an === 4'b1110 && bus.seg !== 7'h40)) begin
                n_err++;
                $display("FAIL lzb_0040 i=%0d an=%b seg=%h", i, bus.an, bus.seg);
            end
            @(negedge clk);
        end
        load({4{7'h40}});
        wait_phase(1);
        lit0 = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (bus.an === 4'b1110) lit0++;
            n_vec++;
            if ((bus.an !== 4'hF && bus.an !== 4'b1110) || bus.an !== e_an) begin
                n_err++;
                $display("FAIL lzb_0000 i=%0d an=%b want only digit 0", i, bus.an);
            end
            @(negedge clk);
        end
        n_vec++;
        if (lit0 != DIV - DEAD) begin
            n_err++;
            $display("FAIL lzb_digit0_lit got %0d want %0d", lit0, DIV - DEAD);
        end
    endtask
`endif

    task automatic test_reset_mid_frame;
        wait_phase(DIV + 5);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_async an=%b seg=%h fs=%b", bus.an, bus.seg, bus.frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.an !== 4'hF || bus.an !== e_an || bus.frame_start !== e_fs) begin
                n_err++;
                $display("FAIL midreset_dark i=%0d an=%b fs=%b/%b", i, bus.an, bus.frame_start, e_fs);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.frame_in   = '0;
        bus.frame_load = 1'b0;
        bus.blank      = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_idle_dark;
        test_load_mid_dig2;
        test_back_to_back;
        test_boundary_load;
        test_blank;
        test_random;
`ifdef SEVEN_SEG_LZB_EN
        test_lzb;
`endif
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
